// File: rtl/fb_stream_pixel_unpacker.sv
// Framebuffer word-to-pixel unpacker: holds one wide word and emits its pixels one per
// clock, checking each frame's pixel count against FRAME_SIZE_IN_PIXELS.
//
// state | meaning
// EMPTY | no word buffered; s_fb_axis_tready high
// FULL  | word buffered; pixels idx..PPW-1 still to be emitted
module fb_stream_pixel_unpacker #(
   parameter int CMD_STREAM_WIDTH     = 64,
   parameter int PIXEL_WIDTH          = 16,
   parameter int FRAME_SIZE_IN_PIXELS = 76800
) (
   input  logic                        aclk,
   input  logic                        resetn,
   input  logic                        s_fb_axis_tvalid,
   output logic                        s_fb_axis_tready,
   input  logic                        s_fb_axis_tlast,
   input  logic [CMD_STREAM_WIDTH-1:0] s_fb_axis_tdata,
   output logic                        m_pixel_axis_tvalid,
   input  logic                        m_pixel_axis_tready,
   output logic                        m_pixel_axis_tlast,
   output logic [PIXEL_WIDTH-1:0]      m_pixel_axis_tdata,
   output logic                        frame_done,
   output logic                        frame_error
);

   localparam int PPW   = CMD_STREAM_WIDTH / PIXEL_WIDTH;
   localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int CNT_W = (FRAME_SIZE_IN_PIXELS > 1) ? $clog2(FRAME_SIZE_IN_PIXELS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PPW - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_SIZE_IN_PIXELS - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t                      state;
   logic [CMD_STREAM_WIDTH-1:0] word_buf;
   logic                        buf_last;
   logic [IDX_W-1:0]            idx;
   logic [CNT_W-1:0]            cnt;

   logic                        buf_valid;
   logic                        last_px;
   logic                        s_hs;
   logic                        m_hs;
   logic [PIXEL_WIDTH-1:0]      px_lane [PPW];

   for (genvar g = 0; g < PPW; g++) begin : g_lane
      assign px_lane[g] = word_buf[g*PIXEL_WIDTH +: PIXEL_WIDTH];
   end

   assign buf_valid = (state == FULL);
   assign last_px   = (idx == IDX_LAST);

   // Refill is allowed on the same edge the final pixel of the current word leaves,
   // which keeps the output gap-free; this is the only input-to-output combinational path.
   assign s_fb_axis_tready    = !buf_valid | (m_pixel_axis_tready & last_px);
   assign m_pixel_axis_tvalid = buf_valid;
   assign m_pixel_axis_tdata  = px_lane[idx];
   assign m_pixel_axis_tlast  = buf_valid & buf_last & last_px;

   assign s_hs = s_fb_axis_tvalid & s_fb_axis_tready;
   assign m_hs = m_pixel_axis_tvalid & m_pixel_axis_tready;

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state       <= EMPTY;
         word_buf    <= '0;
         buf_last    <= 1'b0;
         idx         <= '0;
         cnt         <= '0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         frame_error <= 1'b0;

         if (s_hs) begin
            word_buf <= s_fb_axis_tdata;
            buf_last <= s_fb_axis_tlast;
            state    <= FULL;
            idx      <= '0;
         end else if (m_hs) begin
            if (last_px) begin
               state <= EMPTY;
               idx   <= '0;
            end else begin
               idx <= idx + IDX_W'(1);
            end
         end

         // An overlong frame wraps the counter so the next frame is still measured from zero.
         if (m_hs) begin
            if (m_pixel_axis_tlast) begin
               cnt         <= '0;
               frame_done  <= 1'b1;
               frame_error <= (cnt != CNT_LAST);
            end else if (cnt == CNT_LAST) begin
               cnt         <= '0;
               frame_error <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fb_stream_pixel_unpacker.sv
// Directed bench for fb_stream_pixel_unpacker: 64-bit words, 16-bit pixels, 8-pixel frames.
module tb_fb_stream_pixel_unpacker;

   localparam int CW   = 64;
   localparam int PW   = 16;
   localparam int FS   = 8;
   localparam int MAXL = 64;

   logic          aclk = 1'b0;
   logic          resetn = 1'b0;
   logic          s_fb_axis_tvalid = 1'b0;
   logic          s_fb_axis_tready;
   logic          s_fb_axis_tlast = 1'b0;
   logic [CW-1:0] s_fb_axis_tdata = '0;
   logic          m_pixel_axis_tvalid;
   logic          m_pixel_axis_tready = 1'b0;
   logic          m_pixel_axis_tlast;
   logic [PW-1:0] m_pixel_axis_tdata;
   logic          frame_done;
   logic          frame_error;

   int checks = 0;
   int failures = 0;

   logic [CW-1:0] src_data [8];
   logic          src_last [8];

   int            n_log;
   bit            timed_out;
   logic          lg_mvalid [MAXL];
   logic          lg_mready [MAXL];
   logic [PW-1:0] lg_data   [MAXL];
   logic          lg_last   [MAXL];
   logic          lg_sready [MAXL];
   logic          lg_done   [MAXL];
   logic          lg_err    [MAXL];

   fb_stream_pixel_unpacker #(
      .CMD_STREAM_WIDTH(CW),
      .PIXEL_WIDTH(PW),
      .FRAME_SIZE_IN_PIXELS(FS)
   ) dut (
      .aclk(aclk),
      .resetn(resetn),
      .s_fb_axis_tvalid(s_fb_axis_tvalid),
      .s_fb_axis_tready(s_fb_axis_tready),
      .s_fb_axis_tlast(s_fb_axis_tlast),
      .s_fb_axis_tdata(s_fb_axis_tdata),
      .m_pixel_axis_tvalid(m_pixel_axis_tvalid),
      .m_pixel_axis_tready(m_pixel_axis_tready),
      .m_pixel_axis_tlast(m_pixel_axis_tlast),
      .m_pixel_axis_tdata(m_pixel_axis_tdata),
      .frame_done(frame_done),
      .frame_error(frame_error)
   );

   always #5 aclk = ~aclk;

   // Drives the src_* words and a sink-ready pattern (mode 0: always ready, mode 1:
   // ready every third cycle), logging what is seen just before each rising edge.
   task automatic run_stream(input int n_words, input int mode, input int max_cyc);
      int  wi;
      bit  fin;
      bit  shs;
      wi = 0; n_log = 0; timed_out = 1'b0; fin = 1'b0;
      for (int cyc = 0; cyc < max_cyc && !fin; cyc++) begin
         @(negedge aclk);
         s_fb_axis_tvalid    = (wi < n_words);
         s_fb_axis_tdata     = (wi < n_words) ? src_data[wi] : '0;
         s_fb_axis_tlast     = (wi < n_words) ? src_last[wi] : 1'b0;
         m_pixel_axis_tready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
         #1;
         lg_mvalid[n_log] = m_pixel_axis_tvalid;
         lg_mready[n_log] = m_pixel_axis_tready;
         lg_data[n_log]   = m_pixel_axis_tdata;
         lg_last[n_log]   = m_pixel_axis_tlast;
         lg_sready[n_log] = s_fb_axis_tready;
         lg_done[n_log]   = frame_done;
         lg_err[n_log]    = frame_error;
         n_log++;
         shs = s_fb_axis_tvalid && s_fb_axis_tready;
         if (shs) wi++;
         if (!shs && wi == n_words && !m_pixel_axis_tvalid) fin = 1'b1;
      end
      if (!fin) timed_out = 1'b1;
      @(negedge aclk);
      s_fb_axis_tvalid = 1'b0;
      s_fb_axis_tlast  = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(negedge aclk);
      #1;
      checks++;
      if (m_pixel_axis_tvalid !== 1'b0 || m_pixel_axis_tlast !== 1'b0 || m_pixel_axis_tdata !== 16'h0 ||
          s_fb_axis_tready !== 1'b1 || frame_done !== 1'b0 || frame_error !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: got tvalid=%b tlast=%b tdata=%h s_tready=%b done=%b err=%b, expected 0 0 0000 1 0 0",
                  m_pixel_axis_tvalid, m_pixel_axis_tlast, m_pixel_axis_tdata, s_fb_axis_tready, frame_done, frame_error);
      end
      @(negedge aclk);
      resetn = 1'b1;
   endtask

   task automatic test_single_frame;
      int nd, ne;
      src_data[0] = 64'h0003_0002_0001_0000; src_last[0] = 1'b0;
      src_data[1] = 64'h0007_0006_0005_0004; src_last[1] = 1'b1;
      run_stream(2, 0, 40);
      checks++;
      if (timed_out !== 1'b0 || n_log != 10) begin
         failures++;
         $display("FAIL single_len: got timed_out=%0d cycles=%0d, expected 0 and 10", timed_out, n_log);
      end
      checks++;
      if (lg_mvalid[0] !== 1'b0) begin
         failures++;
         $display("FAIL single_latency: got tvalid=%b in accept cycle, expected 0", lg_mvalid[0]);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (lg_mvalid[1+k] !== 1'b1 || lg_data[1+k] !== 16'(k) || lg_last[1+k] !== (k == 7)) begin
            failures++;
            $display("FAIL single_pixel%0d: got valid=%b data=%h last=%b, expected 1 %h %b",
                     k, lg_mvalid[1+k], lg_data[1+k], lg_last[1+k], 16'(k), (k == 7));
         end
      end
      nd = 0; ne = 0;
      for (int i = 0; i < n_log; i++) begin
         if (lg_done[i]) nd++;
         if (lg_err[i]) ne++;
      end
      checks++;
      if (nd != 1 || lg_done[9] !== 1'b1 || ne != 0) begin
         failures++;
         $display("FAIL single_flags: got done_count=%0d done@9=%b err_count=%0d, expected 1 1 0", nd, lg_done[9], ne);
      end
   endtask

   task automatic test_backpressure;
      int np, bad_hold, bad_sready, nd, ne;
      logic exp_s;
      src_data[0] = 64'h0003_0002_0001_0000; src_last[0] = 1'b0;
      src_data[1] = 64'h0007_0006_0005_0004; src_last[1] = 1'b1;
      run_stream(2, 1, 60);
      checks++;
      if (timed_out !== 1'b0) begin
         failures++;
         $display("FAIL bp_timeout: got timed_out=1, expected 0");
      end
      np = 0; bad_hold = 0; bad_sready = 0; nd = 0; ne = 0;
      for (int i = 0; i < n_log; i++) begin
         if (lg_mvalid[i] && lg_mready[i]) begin
            checks++;
            if (lg_data[i] !== 16'(np) || lg_last[i] !== (np == 7)) begin
               failures++;
               $display("FAIL bp_pixel%0d: got data=%h last=%b, expected %h %b", np, lg_data[i], lg_last[i], 16'(np), (np == 7));
            end
            np++;
         end
         if (lg_mvalid[i] && !lg_mready[i] && i + 1 < n_log) begin
            if (lg_mvalid[i+1] !== 1'b1 || lg_data[i+1] !== lg_data[i] || lg_last[i+1] !== lg_last[i]) bad_hold++;
         end
         exp_s = !lg_mvalid[i] || (lg_mready[i] && lg_data[i][1:0] == 2'd3);
         if (lg_sready[i] !== exp_s) bad_sready++;
         if (lg_done[i]) nd++;
         if (lg_err[i]) ne++;
      end
      checks++;
      if (np != 8) begin
         failures++;
         $display("FAIL bp_count: got %0d pixels, expected 8", np);
      end
      checks++;
      if (bad_hold != 0) begin
         failures++;
         $display("FAIL bp_hold: got %0d unstable stalled cycles, expected 0", bad_hold);
      end
      checks++;
      if (bad_sready != 0) begin
         failures++;
         $display("FAIL bp_s_tready: got %0d wrong s_tready cycles, expected 0", bad_sready);
      end
      checks++;
      if (nd != 1 || ne != 0) begin
         failures++;
         $display("FAIL bp_flags: got done=%0d err=%0d, expected 1 0", nd, ne);
      end
   endtask

   task automatic test_short_frame;
      int bad;
      src_data[0] = 64'h0003_0002_0001_0000; src_last[0] = 1'b1;
      src_data[1] = 64'h0007_0006_0005_0004; src_last[1] = 1'b0;
      src_data[2] = 64'h000b_000a_0009_0008; src_last[2] = 1'b1;
      run_stream(3, 0, 40);
      checks++;
      if (timed_out !== 1'b0 || n_log != 14) begin
         failures++;
         $display("FAIL short_len: got timed_out=%0d cycles=%0d, expected 0 and 14", timed_out, n_log);
      end
      bad = 0;
      for (int k = 0; k < 12; k++)
         if (lg_mvalid[1+k] !== 1'b1 || lg_data[1+k] !== 16'(k) || lg_last[1+k] !== (k == 3 || k == 11)) bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL short_pixels: got %0d bad pixel cycles, expected 0", bad);
      end
      bad = 0;
      for (int i = 0; i < n_log; i++) begin
         if (lg_done[i] !== (i == 5 || i == 13)) bad++;
         if (lg_err[i] !== (i == 5)) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL short_flags: got %0d wrong flag cycles, expected 0 (done@5,13 err@5 only)", bad);
      end
   endtask

   task automatic test_long_frame;
      int bad;
      src_data[0] = 64'h0003_0002_0001_0000; src_last[0] = 1'b0;
      src_data[1] = 64'h0007_0006_0005_0004; src_last[1] = 1'b0;
      src_data[2] = 64'h000b_000a_0009_0008; src_last[2] = 1'b1;
      run_stream(3, 0, 40);
      checks++;
      if (timed_out !== 1'b0 || n_log != 14) begin
         failures++;
         $display("FAIL long_len: got timed_out=%0d cycles=%0d, expected 0 and 14", timed_out, n_log);
      end
      bad = 0;
      for (int k = 0; k < 12; k++)
         if (lg_data[1+k] !== 16'(k) || lg_last[1+k] !== (k == 11)) bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL long_pixels: got %0d bad pixel cycles, expected 0", bad);
      end
      bad = 0;
      for (int i = 0; i < n_log; i++) begin
         if (lg_done[i] !== (i == 13)) bad++;
         if (lg_err[i] !== (i == 9 || i == 13)) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL long_flags: got %0d wrong flag cycles, expected 0 (err@9,13 done@13)", bad);
      end
   endtask

   task automatic test_reset_mid_word;
      int nd, ne;
      @(negedge aclk);
      m_pixel_axis_tready = 1'b1;
      s_fb_axis_tvalid    = 1'b1;
      s_fb_axis_tdata     = 64'h0003_0002_0001_0000;
      s_fb_axis_tlast     = 1'b0;
      @(negedge aclk);
      s_fb_axis_tvalid = 1'b0;
      repeat (2) @(negedge aclk);
      #1;
      checks++;
      if (m_pixel_axis_tvalid !== 1'b1 || m_pixel_axis_tdata !== 16'h0002 || s_fb_axis_tready !== 1'b0) begin
         failures++;
         $display("FAIL rst_pre: got valid=%b data=%h s_tready=%b, expected 1 0002 0",
                  m_pixel_axis_tvalid, m_pixel_axis_tdata, s_fb_axis_tready);
      end
      #1 resetn = 1'b0;
      #1;
      checks++;
      if (m_pixel_axis_tvalid !== 1'b0 || m_pixel_axis_tlast !== 1'b0 || m_pixel_axis_tdata !== 16'h0 ||
          s_fb_axis_tready !== 1'b1 || frame_done !== 1'b0 || frame_error !== 1'b0) begin
         failures++;
         $display("FAIL rst_async: got tvalid=%b tlast=%b tdata=%h s_tready=%b done=%b err=%b, expected 0 0 0000 1 0 0",
                  m_pixel_axis_tvalid, m_pixel_axis_tlast, m_pixel_axis_tdata, s_fb_axis_tready, frame_done, frame_error);
      end
      @(negedge aclk);
      resetn = 1'b1;
      src_data[0] = 64'h0003_0002_0001_0000; src_last[0] = 1'b0;
      src_data[1] = 64'h0007_0006_0005_0004; src_last[1] = 1'b1;
      run_stream(2, 0, 40);
      nd = 0; ne = 0;
      for (int i = 0; i < n_log; i++) begin
         if (lg_done[i]) nd++;
         if (lg_err[i]) ne++;
      end
      checks++;
      if (timed_out !== 1'b0 || nd != 1 || ne != 0 || lg_done[9] !== 1'b1) begin
         failures++;
         $display("FAIL rst_after: got timed_out=%0d done=%0d err=%0d done@9=%b, expected 0 1 0 1",
                  timed_out, nd, ne, lg_done[9]);
      end
   endtask

   task automatic test_back_to_back;
      int bad;
      src_data[0] = 64'h0003_0002_0001_0000; src_last[0] = 1'b0;
      src_data[1] = 64'h0007_0006_0005_0004; src_last[1] = 1'b1;
      src_data[2] = 64'h000b_000a_0009_0008; src_last[2] = 1'b0;
      src_data[3] = 64'h000f_000e_000d_000c; src_last[3] = 1'b1;
      run_stream(4, 0, 40);
      checks++;
      if (timed_out !== 1'b0 || n_log != 18) begin
         failures++;
         $display("FAIL b2b_len: got timed_out=%0d cycles=%0d, expected 0 and 18", timed_out, n_log);
      end
      bad = 0;
      for (int k = 0; k < 16; k++)
         if (lg_mvalid[1+k] !== 1'b1 || lg_data[1+k] !== 16'(k) || lg_last[1+k] !== (k == 7 || k == 15)) bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL b2b_pixels: got %0d bad cycles in 16-cycle run, expected 0", bad);
      end
      bad = 0;
      for (int i = 0; i < n_log; i++) begin
         if (lg_done[i] !== (i == 9 || i == 17)) bad++;
         if (lg_err[i] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL b2b_flags: got %0d wrong flag cycles, expected 0 (done@9,17 no err)", bad);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_backpressure();
      test_short_frame();
      test_long_frame();
      test_reset_mid_word();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
